tt_um_factory_test_gen2_crnicholson: RTL and testbench

TT_UM_FACTORY_TEST_GEN2_CRNICHOLSON -- requirements
Module: tt_um_factory_test_gen2_crnicholson

---
 rtl/tt_factory_test_pkg.sv | 38 +++
 rtl/tt_rst_sync.sv | 30 +++
 rtl/tt_um_factory_test_gen2_crnicholson.sv | 171 +++++++++++++++++
 tb/tb_tt_um_factory_test_gen2_crnicholson.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_factory_test_pkg.sv
// ---------------------------------------------------------------------------
// tt_factory_test_pkg
// Shared definitions for the factory-test pattern generator:
//   mode_e            operating mode carried in ui_in[1:0]
//   ctrl_t            field view of the ui_in control byte
//   LFSR_TAPS         tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   LFSR_SEED_DEFAULT reset value of the PRBS register
//   lfsr_next()       one left shift of the Fibonacci LFSR
// ---------------------------------------------------------------------------
package tt_factory_test_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP  = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_PRBS  = 2'b10,
    MODE_STEP  = 2'b11
  } mode_e;

  // Bit 7 down to bit 0 of ui_in.
  typedef struct packed {
    logic       step;
    logic       hold;
    logic       hi_sel;
    logic [1:0] presc_sel;
    logic       down;
    mode_e      mode;
  } ctrl_t;

  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;

  // Shift left, XOR of the tapped bits enters at bit 0. A non-zero state
  // never maps to zero for this maximal-length polynomial.
  function automatic logic [7:0] lfsr_next(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tt_rst_sync.sv
// ---------------------------------------------------------------------------
// tt_rst_sync
// Reset synchroniser: asynchronous assertion, synchronous release through
// two flops. rst_i rises on the second clk edge after rst_n is released.
//   clk    input   clock
//   rst_n  input   external reset, asynchronous, active-low
//   rst_i  output  internal reset, active-low
// ---------------------------------------------------------------------------
module tt_rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_i
);

  logic stage1;
  logic stage2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
    end else begin
      stage1 <= 1'b1;
      stage2 <= stage1;
    end
  end

  assign rst_i = stage2;

endmodule

// File: rtl/tt_um_factory_test_gen2_crnicholson.sv
// ---------------------------------------------------------------------------
// tt_um_factory_test_gen2_crnicholson
// Factory-test pattern generator: loopback, prescaled up/down counter,
// 8-bit PRBS and a strobe-stepped counter, observed on uo_out and driven
// inverted on the bidirectional pins.
//   clk      input   clock
//   rst_n    input   reset, asynchronous, active-low
//   ena      input   power-good (not used)
//   ui_in    input   [1:0] mode, [2] down, [4:3] prescale sel, [5] high byte,
//                    [6] hold, [7] step strobe
//   uo_out   output  observed data byte (ui_in while rst_n is low)
//   uio_in   input   loopback data
//   uio_out  output  inverted data byte in non-loop modes
//   uio_oe   output  bidirectional enable, 1 = drive
// ---------------------------------------------------------------------------
module tt_um_factory_test_gen2_crnicholson
  import tt_factory_test_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter int         DIV_STEP  = 4,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PRE_W = 3 * DIV_STEP;

  // A zero seed would lock the LFSR at zero; fall back to the default.
  localparam logic [7:0] SEED_SAFE =
    (LFSR_SEED == 8'h00) ? LFSR_SEED_DEFAULT : LFSR_SEED;

  ctrl_t            ctrl;
  logic             rst_i;
  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] presc;
  logic [PRE_W-1:0] presc_mask;
  logic [7:0]       lfsr;
  logic             step_s1;
  logic             step_s2;
  logic             step_s3;
  logic             tick;
  logic             step_edge;
  logic             cnt_en;
  logic             lfsr_en;
  logic [7:0]       cnt_hi;
  logic [7:0]       data;
  logic             unused_ok;

  assign ctrl      = ctrl_t'(ui_in);
  assign unused_ok = &{1'b0, ena};

  tt_rst_sync u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rst_i (rst_i)
  );

  // Tick when the low sel*DIV_STEP prescaler bits are all ones; sel=0 gives
  // an empty mask and therefore a tick every cycle.
  always_comb begin
    presc_mask = '0;
    for (int i = 0; i < PRE_W; i++) begin
      presc_mask[i] = (i < int'(ctrl.presc_sel) * DIV_STEP);
    end
  end

  assign tick      = ((presc & presc_mask) == presc_mask);
  assign step_edge = step_s2 & ~step_s3;

  // Only the active mode's register advances; hold freezes everything.
  always_comb begin
    cnt_en  = 1'b0;
    lfsr_en = 1'b0;
    if (!ctrl.hold) begin
      case (ctrl.mode)
        MODE_COUNT: cnt_en  = tick;
        MODE_PRBS:  lfsr_en = tick;
        MODE_STEP:  cnt_en  = step_edge;
        default:    ;
      endcase
    end
  end

  // Strobe synchroniser and edge flop keep running during hold, so an edge
  // seen while held is consumed rather than replayed afterwards.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= ctrl.step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      presc <= '0;
    end else if (!ctrl.hold) begin
      presc <= presc + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (cnt_en) begin
      if (ctrl.down) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      lfsr <= SEED_SAFE;
    end else if (lfsr_en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // High byte reads zero above the counter's top bit.
  generate
    if (CNT_W >= 16) begin : g_hi_full
      assign cnt_hi = cnt[15:8];
    end else if (CNT_W > 8) begin : g_hi_part
      assign cnt_hi = {{(16 - CNT_W){1'b0}}, cnt[CNT_W-1:8]};
    end else begin : g_hi_none
      assign cnt_hi = 8'h00;
    end
  endgenerate

  always_comb begin
    data = ctrl.hi_sel ? cnt_hi : cnt[7:0];
    if (ctrl.mode == MODE_PRBS) begin
      data = lfsr;
    end
  end

  // External reset bypasses straight to ui_in; the pins stay released until
  // the synchronised reset has gone high.
  always_comb begin
    uo_out  = data;
    uio_out = ~data;
    uio_oe  = 8'hFF;
    if (ctrl.mode == MODE_LOOP) begin
      uo_out  = uio_in;
      uio_out = 8'h00;
      uio_oe  = 8'h00;
    end
    if (!rst_i) begin
      uio_out = 8'h00;
      uio_oe  = 8'h00;
    end
    if (!rst_n) begin
      uo_out = ui_in;
    end
  end

endmodule

// File: tb/tb_tt_um_factory_test_gen2_crnicholson.sv
module tb_tt_um_factory_test_gen2_crnicholson;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_factory_test_gen2_crnicholson dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: counter as an integer modulo 2^16, prescaler as
  // a count of un-held cycles since reset, reset release as an edge count.
  int         m_cnt;
  int         m_presc;
  int         m_rsync;
  logic [7:0] m_lfsr;
  logic       m_h1, m_h2, m_h3;

  function automatic logic [7:0] prbs_next(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_presc = 0;
    m_rsync = 0;
    m_lfsr  = 8'h01;
    m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0;
  endtask

  task automatic model_edge();
    int  mode, span;
    bit  edge_seen, tick;
    if (!rst_n) return;
    if (m_rsync < 2) begin
      m_rsync++;
      return;
    end
    edge_seen = m_h2 && !m_h3;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = ui_in[7];
    if (!ui_in[6]) begin
      mode = int'(ui_in[1:0]);
      span = 1 << (int'(ui_in[4:3]) * 4);
      tick = ((m_presc + 1) % span) == 0;
      if ((mode == 1 && tick) || (mode == 3 && edge_seen))
        m_cnt = ui_in[2] ? (m_cnt + 65535) % 65536 : (m_cnt + 1) % 65536;
      if (mode == 2 && tick)
        m_lfsr = prbs_next(m_lfsr);
      m_presc = (m_presc + 1) % 4096;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] e_uo, e_out, e_oe, d;
    d = (ui_in[1:0] == 2'b10) ? m_lfsr
      : (ui_in[5] ? 8'(m_cnt / 256) : 8'(m_cnt % 256));
    if (ui_in[1:0] == 2'b00) begin
      e_uo = uio_in; e_out = 8'h00; e_oe = 8'h00;
    end else begin
      e_uo = d; e_out = ~d; e_oe = 8'hFF;
    end
    if (m_rsync < 2) begin
      e_out = 8'h00; e_oe = 8'h00;
    end
    if (!rst_n) e_uo = ui_in;
    chk({tag, "_uo"},  uo_out,  e_uo);
    chk({tag, "_out"}, uio_out, e_out);
    chk({tag, "_oe"},  uio_oe,  e_oe);
  endtask

  // Ends 2 time units after the active edge, leaving inputs free to change.
  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      clk_step();
      check_outputs(tag);
    end
  endtask

  // One-cycle reset pulse, entered 2 units after an edge.
  task automatic do_reset(input logic [7:0] u);
    ui_in = u;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_bypass", uo_out, u);
    check_outputs("rst_low");
    clk_step();
    check_outputs("rst_low_edge");
    rst_n = 1'b1;
    #1;
    check_outputs("rst_rel");
  endtask

  initial begin
    int         zeros, first_ret;
    logic [7:0] exp_seq [4];
    logic [31:0] r;
    logic [7:0] u;

    exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08; exp_seq[3] = 8'h11;

    // Reset bypass and release timing
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'hA5; uio_in = 8'h00;
    model_reset();
    #3;
    chk("reset_uo", uo_out, 8'hA5);
    chk("reset_oe", uio_oe, 8'h00);
    check_outputs("reset");
    ui_in = 8'h01;
    run(2, "reset_held");
    rst_n = 1'b1;
    #1;
    check_outputs("release");
    run(2, "sync");
    chk("count_first", uo_out, 8'h00);
    run(1, "count");
    chk("count_second", uo_out, 8'h01);
    run(1, "count");
    chk("count_third", uo_out, 8'h02);

    // Loopback, same cycle
    ui_in = 8'h00; uio_in = 8'h3C;
    #1;
    chk("loop_uo", uo_out, 8'h3C);
    chk("loop_oe", uio_oe, 8'h00);
    check_outputs("loop");

    // Prescale sel=1 counting down, wrap from zero
    do_reset(8'h0D);
    run(2, "psc_sync");
    run(16, "psc_down");
    chk("wrap_lo", uo_out, 8'hFF);
    ui_in = 8'h2D;
    #1;
    chk("wrap_hi_uo", uo_out, 8'hFF);
    chk("wrap_hi_out", uio_out, 8'h00);
    ui_in = 8'h21;
    run(1, "wrap_up");
    chk("wrap_up_hi", uo_out, 8'h00);

    // PRBS sequence and period
    do_reset(8'h02);
    run(2, "prbs_sync");
    chk("prbs_seed", uo_out, 8'h01);
    zeros = 0; first_ret = 0;
    for (int k = 1; k <= 255; k++) begin
      clk_step();
      check_outputs("prbs");
      if (k <= 4) chk("prbs_seq", uo_out, exp_seq[k-1]);
      if (uo_out == 8'h00) zeros++;
      if (uo_out == 8'h01 && first_ret == 0) first_ret = k;
    end
    chk("prbs_zero_seen", zeros, 0);
    chk("prbs_period", first_ret, 255);

    // Step strobe, then hold discards edges
    do_reset(8'h03);
    run(2, "step_sync");
    repeat (3) begin
      ui_in = 8'h83; run(3, "step_hi");
      ui_in = 8'h03; run(3, "step_lo");
    end
    chk("step_count", uo_out, 8'h03);
    repeat (2) begin
      ui_in = 8'hC3; run(3, "hold_hi");
      ui_in = 8'h43; run(3, "hold_lo");
    end
    ui_in = 8'h03;
    run(4, "hold_off");
    chk("hold_count", uo_out, 8'h03);

    // Mid-count reset at 0x1234
    do_reset(8'h01);
    run(2, "mid_sync");
    for (int k = 0; k < 5000 && m_cnt != 32'h1234; k++) begin
      clk_step();
      check_outputs("mid_run");
    end
    chk("mid_reached", m_cnt, 32'h1234);
    chk("mid_lo", uo_out, 8'h34);
    ui_in = 8'h21;
    #1;
    chk("mid_hi", uo_out, 8'h12);
    do_reset(8'h21);
    chk("mid_cnt_clr", uo_out, 8'h00);
    ui_in = 8'h02;
    #1;
    chk("mid_lfsr_seed", uo_out, 8'h01);
    run(3, "mid_after");

    // Randomised operation against the reference model
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      u = r[7:0];
      if (r[15:13] != 3'b000) u[4:3] = {1'b0, r[8]};
      u[6] = (r[12:10] == 3'b000);
      ui_in  = u;
      uio_in = r[23:16];
      #1;
      check_outputs("rand_in");
      clk_step();
      check_outputs("rand_edge");
      if (r[31:24] == 8'h00) do_reset(u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
